// File: rtl/float_div_unit.sv
// float_div_unit: iterative binary32 divider (restoring radix-2, RNE, denormals flushed) behind an enable/done handshake.
module float_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, LOAD, DIVIDE, ROUND, DONE} state_t;
  localparam logic [1:0] SP_NORM = 2'd0, SP_NAN = 2'd1, SP_INF = 2'd2, SP_ZERO = 2'd3;
  state_t state, state_nx;
  logic [31:0] a, b;
  logic sign;
  logic signed [9:0] exp;
  logic [25:0] rem, q;
  logic [23:0] mb;
  logic [4:0] cnt;
  logic [1:0] spec;
  logic [7:0] ea, eb;
  logic az, bz, ai, bi, an, bn, ma_lt, ge;
  logic [23:0] ma;
  logic [1:0] spec_n;
  logic signed [9:0] exp_n, exp_r;
  logic [25:0] rem_nx;
  logic [24:0] sum;
  logic [22:0] frac_r;
  logic [31:0] rnd;
  assign ea = a[30:23];
  assign eb = b[30:23];
  assign az = ea == 8'd0;
  assign bz = eb == 8'd0;
  assign ai = ea == 8'hFF && a[22:0] == 23'd0;
  assign bi = eb == 8'hFF && b[22:0] == 23'd0;
  assign an = ea == 8'hFF && a[22:0] != 23'd0;
  assign bn = eb == 8'hFF && b[22:0] != 23'd0;
  assign ma = {1'b1, a[22:0]};
  assign ma_lt = ma < {1'b1, b[22:0]};
  assign exp_n = 10'({2'b00, ea}) - 10'({2'b00, eb}) + 10'd127 - 10'(ma_lt);
  assign spec_n = (an | bn | (ai & bi) | (az & bz)) ? SP_NAN :
                  (ai | bz) ? SP_INF : (bi | az) ? SP_ZERO : SP_NORM;
  assign ge = rem >= {2'b00, mb};
  assign rem_nx = (ge ? rem - {2'b00, mb} : rem) << 1;
  // q = hidden, 23 fraction, guard, round; the leftover remainder is the sticky bit
  assign sum = {1'b0, q[25:2]} + 25'(q[1] & (q[0] | (|rem) | q[2]));
  assign exp_r = exp + 10'(sum[24]);
  assign frac_r = sum[24] ? sum[23:1] : sum[22:0];
  assign rnd = spec == SP_NAN ? 32'h7FC0_0000 :
               (spec == SP_INF || (spec == SP_NORM && exp_r >= 10'sd255)) ? {sign, 31'h7F80_0000} :
               (spec == SP_ZERO || exp_r <= 10'sd0) ? {sign, 31'd0} :
               {sign, exp_r[7:0], frac_r};
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = enable ? LOAD : IDLE;
      LOAD:    state_nx = enable ? DIVIDE : IDLE;
      DIVIDE:  state_nx = !enable ? IDLE : cnt == 5'd25 ? ROUND : DIVIDE;
      ROUND:   state_nx = enable ? DONE : IDLE;
      default: state_nx = enable ? DONE : IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      result <= 32'd0;
      done <= 1'b0;
    end else begin
      done <= state_nx == DONE;
      if (state == ROUND && enable) result <= rnd;
    end
    if (state == IDLE && enable) begin
      a <= dataa;
      b <= datab;
    end
    if (state == LOAD) begin
      sign <= a[31] ^ b[31];
      exp <= exp_n;
      mb <= {1'b1, b[22:0]};
      rem <= ma_lt ? {1'b0, ma, 1'b0} : {2'b00, ma};
      q <= 26'd0;
      cnt <= 5'd0;
      spec <= spec_n;
    end
    if (state == DIVIDE) begin
      rem <= rem_nx;
      q <= {q[24:0], ge};
      cnt <= cnt + 5'd1;
    end
  end
endmodule

// File: tb/tb_float_div_unit.sv
// tb_float_div_unit: directed and random checks of float_div_unit against an exact-arithmetic RNE reference.
module tb_float_div_unit;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, done;
  logic [31:0] dataa = 32'd0, datab = 32'd0, result;
  int n_assert = 0, n_fail = 0;
  float_div_unit dut (.clk(clk), .reset(reset), .enable(enable), .dataa(dataa), .datab(datab), .result(result), .done(done));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask
  // exact quotient by wide integer division, then round-to-nearest-even on the true value
  function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] y);
    logic s;
    int ex, ey, e, sh;
    logic xz, yz, xi, yi, xn, yn, g, st;
    logic [127:0] n, d, qq, rm, mask;
    logic [24:0] m;
    s = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xz = ex == 0; yz = ey == 0;
    xi = ex == 255 && x[22:0] == 0; yi = ey == 255 && y[22:0] == 0;
    xn = ex == 255 && x[22:0] != 0; yn = ey == 255 && y[22:0] != 0;
    if (xn || yn || (xi && yi) || (xz && yz)) return 32'h7FC0_0000;
    if (xi || yz) return {s, 31'h7F80_0000};
    if (yi || xz) return {s, 31'd0};
    n = 128'({1'b1, x[22:0]}) << 60;
    d = 128'({1'b1, y[22:0]});
    qq = n / d;
    rm = n % d;
    e = ex - ey + 127;
    if (qq[60]) sh = 37;
    else begin
      sh = 36;
      e--;
    end
    m = 25'(qq >> sh);
    g = qq[sh-1];
    mask = (128'd1 << (sh - 1)) - 128'd1;
    st = ((qq & mask) != 0) || (rm != 0);
    if (g && (st || m[0])) m = m + 25'd1;
    if (m[24]) begin
      m = m >> 1;
      e++;
    end
    if (e >= 255) return {s, 31'h7F80_0000};
    if (e <= 0) return {s, 31'd0};
    return {s, 8'(e), m[22:0]};
  endfunction
  function automatic logic [31:0] rnd_op();
    if ($urandom_range(0, 4) == 0) return $urandom;
    return {1'($urandom), 8'($urandom_range(90, 165)), 23'($urandom)};
  endfunction
  task automatic do_op(input string tag, input logic [31:0] x, input logic [31:0] y, input logic [31:0] want, input int hold);
    int k;
    logic [31:0] r;
    @(negedge clk);
    dataa = x; datab = y; enable = 1'b1;
    @(posedge clk);
    #1;
    dataa = $urandom; datab = $urandom;
    k = 0;
    while (done !== 1'b1 && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({tag, " latency"}, 32'(k), 32'd28);
    chk({tag, " result"}, result, want);
    r = result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, " done held"}, 32'(done), 32'd1);
      chk({tag, " result held"}, result, r);
    end
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, " done fall"}, 32'(done), 32'd0);
    chk({tag, " result after"}, result, r);
  endtask
  initial begin
    logic [31:0] x, y, prev;
    bit seen;
    repeat (3) @(posedge clk);
    #1;
    chk("reset result", result, 32'd0);
    chk("reset done", 32'(done), 32'd0);
    reset = 1'b0;
    do_op("6/2", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 3);
    do_op("1/3", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 0);
    do_op("1/0", 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 0);
    do_op("0/0", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 0);
    do_op("-8/inf", 32'hC100_0000, 32'h7F80_0000, 32'h8000_0000, 0);
    do_op("nan/1", 32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 0);
    do_op("overflow", 32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 0);
    do_op("underflow", 32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 0);
    do_op("denormal", 32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 0);
    do_op("7/-2", 32'h40E0_0000, 32'hC000_0000, 32'hC060_0000, 1);
    prev = result;
    @(negedge clk);
    dataa = 32'h4120_0000; datab = 32'h4040_0000; enable = 1'b1;
    @(posedge clk);
    repeat (11) @(posedge clk);
    #1;
    enable = 1'b0;
    seen = 0;
    repeat (35) begin
      @(posedge clk);
      #1;
      if (done) seen = 1;
    end
    chk("abort done", 32'(seen), 32'd0);
    chk("abort result", result, prev);
    @(negedge clk);
    dataa = 32'h40C0_0000; datab = 32'h4000_0000; enable = 1'b1;
    @(posedge clk);
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset done", 32'(done), 32'd0);
    chk("midreset result", result, 32'd0);
    reset = 1'b0;
    enable = 1'b0;
    @(posedge clk);
    do_op("6/2 again", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 0);
    for (int i = 0; i < 14; i++) begin
      x = rnd_op();
      y = rnd_op();
      do_op($sformatf("rand%0d %h/%h", i, x, y), x, y, ref_div(x, y), (i % 2 == 0) ? 5 : 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/float_div_unit.md
# float_div_unit

- Iterative IEEE-754 single-precision divider, result = dataa / datab.
- Responder side of the datapath's enable/done handshake: a sequencing top asserts enable, waits for done, latches result, then drops enable.
- Sits beside the existing mult/add/sub units as a drop-in functional unit for formula pipelines needing division.
- Radix-2 restoring, one quotient bit per cycle, fixed latency, round-to-nearest-even, denormals flushed to zero.

## Interface
- No parameters; fixed binary32 format.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  level request; operands sampled on the edge that sees enable=1 in IDLE.
- dataa  input  32  dividend, binary32.
- datab  input  32  divisor, binary32.
- result  output  32  quotient, registered; reset value 0x00000000.
- done  output  1  registered; reset value 0.

## Operation
- States: IDLE, LOAD, DIVIDE, ROUND, DONE.
- IDLE, enable=1:
  - capture dataa/datab into internal registers;
  - go to LOAD.
- LOAD:
  - unpack sign = sa^sb;
  - a zero exponent field means the operand is zero (denormal flush);
  - add the hidden 1 to form 24-bit ma, mb;
  - exp = ea - eb + 127, held in a signed 10-bit register;
  - if ma < mb: ma <<= 1, exp -= 1;
  - classify special cases;
  - load the remainder, clear the quotient and iteration counter;
  - go to DIVIDE.
- DIVIDE, 26 iterations: each cycle, if rem >= mb then rem -= mb and shift in 1, else shift in 0; then rem <<= 1.
- Quotient layout: 26 bits = hidden + 23 fraction + guard + round. sticky = (final rem != 0).
- DIVIDE exits to ROUND after iteration 26.
- ROUND: RNE, increment when guard & (round | sticky | lsb).
  - Mantissa carry-out: shift right, exp += 1.
  - exp >= 255: result {sign, 0x7F800000 magnitude}.
  - exp <= 0: signed zero.
  - Otherwise pack {sign, exp[7:0], frac[22:0]}.
  - Register result, set done=1, go to DONE.
- Special cases take the same latency; their value is written in ROUND:
  - either operand NaN: 0x7FC00000.
  - inf/inf or 0/0: 0x7FC00000.
  - finite nonzero / 0: signed inf.
  - inf / finite: signed inf.
  - finite / inf: signed zero.
  - 0 / nonzero finite: signed zero.
- DONE:
  - done=1, result held while enable=1; no recompute while enable stays high.
  - enable=0: go to IDLE, done=0 on that edge.
- Abort: enable=0 sampled in LOAD/DIVIDE/ROUND returns to IDLE; done stays 0, result unchanged.
- reset=1 on any edge, any state: go to IDLE with done=0, result=0x00000000. Overrides enable on that edge.
- result changes only in ROUND or on reset. It holds its last value in IDLE after done falls.

## Timing
- Capture edge E0 (IDLE, enable=1), then:
  - E1: LOAD;
  - E2..E27: the 26 DIVIDE iterations;
  - E28: ROUND writes result and done.
- done is high 28 cycles after the capture edge.
- Operand changes after E0 have no effect on the current operation.
- done falls on the first edge that sees enable=0 in DONE.
- A new operation needs enable sampled 0 for at least one edge, then 1 in IDLE. Minimum back-to-back period is 30 cycles.
- Sequencing-top convention: the top holds enable high from request until it sees done, then drops it. Done-to-enable-low latency is unbounded; the unit waits in DONE indefinitely.

## Test plan
- 6.0 / 2.0 (0x40C00000 / 0x40000000), enable held:
  - result=0x40400000, done rises exactly 28 cycles after capture;
  - done holds until enable drops, then falls next edge.
- 1.0 / 3.0 (0x3F800000 / 0x40400000) -> 0x3EAAAAAB, checking RNE round-up.
- Specials:
  - 1.0 / 0.0 -> 0x7F800000;
  - 0.0 / 0.0 -> 0x7FC00000;
  - -8.0 / +inf (0xC1000000 / 0x7F800000) -> 0x80000000;
  - 0x7FC00001 / 1.0 -> 0x7FC00000.
- Range:
  - 0x7F000000 / 0x00800000 -> 0x7F800000 (overflow);
  - 0x00800000 / 0x40000000 -> 0x00000000 (underflow flush);
  - denormal 0x00000001 / 1.0 -> 0x00000000.
- Abort and reset:
  - enable dropped at cycle 10 of DIVIDE: done never rises, result unchanged;
  - reset asserted mid-DIVIDE: next edge done=0, result=0x00000000;
  - a fresh 6.0 / 2.0 request then completes normally at +28.
- Back-to-back with randomized operands against a reference model:
  - enable held 5 extra cycles in DONE: no second done pulse;
  - the second request returns the correct second quotient.
